// File: rtl/serial_addsub_seq_if.sv
// Handshake and operand/result bundle for serial_addsub_seq.
//   start  controller -> sequencer  request, taken only while busy is low
//   a, b   controller -> sequencer  W-bit operands, captured with start
//   m      controller -> sequencer  0 = a+b, 1 = a-b
//   busy   sequencer -> controller  nibbles in flight
//   done   sequencer -> controller  one-cycle completion pulse
//   s      sequencer -> controller  W-bit result, held until next completion
//   cout   sequencer -> controller  final carry (for subtract: 1 = no borrow)
//   ovf    sequencer -> controller  signed overflow of s
interface serial_addsub_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         m;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, m,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, m,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_seq.sv
// Multi-precision add/subtract sequencer. A single 4-bit add slice with
// carry-in is reused across the nibbles of a W = 4*NIBBLES operand pair,
// LSB nibble first, one nibble per clock; the carry is kept in a register.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    slave side of serial_addsub_seq_if (start/a/b/m in,
//          busy/done/s/cout/ovf out)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one nibble per cycle through the shared slice
// DONE  | result valid, done pulse; a new start goes straight back to RUN
module serial_addsub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  serial_addsub_seq_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          m_q, m_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  s_q, s_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [4:0]    sum5;
  logic [3:0]    low3;

  // Shared slice: subtract is a + ~b + 1, the +1 coming from carry seeded with m.
  always_comb begin
    nib_a = a_q[{idx_q, 2'b00} +: 4];
    nib_b = b_q[{idx_q, 2'b00} +: 4] ^ {4{m_q}};
    sum5  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry_q};
    // Carry into the nibble's top bit; on the last nibble this is the carry into bit W-1.
    low3  = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, carry_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          m_d     = bus.m;
          carry_d = bus.m;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[{idx_q, 2'b00} +: 4] = sum5[3:0];
        carry_d = sum5[4];
        if (idx_q == LAST) begin
          // s is only written here so partial accumulations never show.
          s_d     = acc_d;
          cout_d  = sum5[4];
          ovf_d   = low3[3] ^ sum5[4];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
